fpu_issuer: RTL
===============

// Module: fpu_issuer
// PURPOSE
//  Initiator side of the FPU order/accepted/done handshake. Takes one FP request from the core
//  (valid/ready), drives order to a single FPU unit (fmul, fadd, ...), and holds operands stable
//  until the unit finishes. Captures rd on done and returns it with the request tag.
//  Sits between the core's execute stage and each FPU unit; one instance per unit.
// PARAMETERS
//  DATA_W          32  operand/result width
//  TAG_W           5   request tag width (destination register id), returned unchanged
//  TIMEOUT_CYCLES  64  watchdog limit in WAIT (used only with FPU_ISSUE_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       core request present
//  req_ready  out  1       issuer can take a request (IDLE only)
//  req_rs1    in   DATA_W  operand 1
//  req_rs2    in   DATA_W  operand 2
//  req_tag    in   TAG_W   request tag
//  fpu_order  out  1       order to unit
//  fpu_accepted in 1       unit took the order
//  fpu_done   in   1       one-cycle pulse, fpu_rd valid in this cycle only
//  fpu_rs1    out  DATA_W  latched operand 1, stable from IDLE exit until RESP exit
//  fpu_rs2    out  DATA_W  latched operand 2, same stability
//  fpu_rd     in   DATA_W  unit result
//  rsp_valid  out  1       result available
//  rsp_ready  in   1       core consumes result
//  rsp_data   out  DATA_W  captured result
//  rsp_tag    out  TAG_W   tag of the request
//  rsp_err    out  1       watchdog expiry (tied 0 without FPU_ISSUE_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async): state=IDLE; req_ready=1; fpu_order=0; rsp_valid=0; rsp_err=0;
//    fpu_rs1/fpu_rs2/rsp_data=0; rsp_tag=0; watchdog=0. A reset mid-operation abandons the op
//    without a response. The unit shares rst, so it is cleared too.
//  - FSM states: IDLE, ORDER, WAIT, RESP. req_ready = (state==IDLE). rsp_valid = (state==RESP).
//    fpu_order = (state==ORDER).
//  - IDLE: on req_valid, latch rs1/rs2/tag and go to ORDER. The request is taken in that cycle.
//  - ORDER: fpu_order held high until fpu_accepted.
//      accepted & ~done -> WAIT.
//      accepted & done (same cycle, zero-latency unit) -> capture fpu_rd, go to RESP.
//      done without accepted -> ignored (protocol violation, stays ORDER).
//  - WAIT: fpu_order=0. On fpu_done, capture fpu_rd into rsp_data and go to RESP.
//  - RESP: hold rsp_data/tag/err. On rsp_ready, go to IDLE.
//    No bypass: a new request is taken no earlier than the cycle after the RESP handshake.
//  - Latency: req handshake to rsp_valid = 1 (ORDER) + unit accept delay + unit latency + 1.
//    With fmul (accept in 1st ORDER cycle, done 3 cycles later), rsp_valid rises 5 cycles
//    after the req handshake.
//  - Throughput: one outstanding op; fpu_done outside WAIT/ORDER is ignored.
//  - Operands on fpu_rs1/fpu_rs2 change only on the IDLE->ORDER transition.
// CONFIGURATION
//  FPU_ISSUE_TIMEOUT_EN defined:
//    - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entering WAIT and increments each WAIT cycle.
//    - If it reaches TIMEOUT_CYCLES without done: go to RESP with rsp_data=32'h7FC00000 (qNaN)
//      and rsp_err=1. rsp_err clears on leaving RESP.
//    - done arriving in the expiry cycle takes priority (normal result, err=0).
//  Not defined: no counter, rsp_err tied 0, WAIT waits indefinitely.
// TESTING
//  1 fmul-latency model (accept immediately, done 3 cycles later, rd=32'h40C00000);
//    req rs1=32'h40000000 rs2=32'h40400000 tag=5'd7
//    -> order high 1 cycle; rsp_valid 5 cycles after req; data=40C00000, tag=7, err=0.
//  2 Unit holds accepted low 4 cycles -> fpu_order high 5 cycles; operands unchanged throughout;
//    rsp delayed by 4 cycles.
//  3 accepted & done in same cycle, rd=32'h3F800000 -> RESP next cycle, no WAIT, data=3F800000.
//  4 rsp_ready low 6 cycles in RESP -> rsp_valid/data/tag stable; req_ready=0; a second req_valid
//    is not taken until the cycle after the rsp handshake.
//  5 Assert rst 2 cycles during WAIT -> immediately order=0, rsp_valid=0, req_ready=1;
//    a stale done after reset produces no response.
//  6 (FPU_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=8) unit never sends done
//    -> rsp_valid 8 cycles after entering WAIT, data=7FC00000, err=1;
//    done injected exactly at cycle 8 -> normal data, err=0.

Source files
------------

// File: rtl/fpu_issuer.sv
// Initiator side of the FPU order/accepted/done handshake: one outstanding op per unit.
// Optional watchdog in WAIT enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issuer #(
  parameter int DATA_W         = 32,
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              fpu_order,
  input  logic              fpu_accepted,
  input  logic              fpu_done,
  output logic [DATA_W-1:0] fpu_rs1,
  output logic [DATA_W-1:0] fpu_rs2,
  input  logic [DATA_W-1:0] fpu_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ORDER, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

  logic [WD_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic            err_q, err_d;

  assign wdog_inc = wdog_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    tag_d   = tag_q;
    data_d  = data_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          tag_d   = req_tag;
          state_d = S_ORDER;
        end
      end
      S_ORDER: begin
        // done without accepted is a unit protocol violation and is dropped
        if (fpu_accepted) begin
          if (fpu_done) begin
            data_d  = fpu_rd;
            state_d = S_RESP;
`ifdef FPU_ISSUE_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end else begin
            state_d = S_WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (fpu_done) begin
          data_d  = fpu_rd;
          state_d = S_RESP;
`ifdef FPU_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wdog_inc == WD_W'(TIMEOUT_CYCLES)) begin
          // done in the expiry cycle wins over the timeout (branch above)
          data_d  = QNAN;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_inc;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
`ifdef FPU_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign fpu_order = (state_q == S_ORDER);
  assign rsp_valid = (state_q == S_RESP);
  assign fpu_rs1   = rs1_q;
  assign fpu_rs2   = rs2_q;
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;

endmodule
